// File: rtl/result_stream_writer.sv
// Result stream writer: packs a byte stream into little-endian 32-bit words,
// buffers them in a small word FIFO and writes each frame to memory through an
// Avalon-MM write master, starting every frame at BASE_ADDR.
module result_stream_writer #(
  parameter int ADDR_W     = 17,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  input  logic              st_sof,
  input  logic              st_eof,
  output logic              st_ready,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_write,
  output logic [31:0]       avl_writedata,
  output logic [3:0]        avl_byteenable,
  input  logic              avl_waitrequest,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_sync
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Word seen by the FIFO: lanes below the current lane come from the held
  // bytes, the current lane is the incoming byte, lanes above are zero.
  function automatic logic [31:0] merge_word(input logic [31:0] held,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(lane))
        w[i*8 +: 8] = held[i*8 +: 8];
      else if (i == int'(lane))
        w[i*8 +: 8] = data;
    end
    return w;
  endfunction

  // Byte enables for lanes 0..lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(lane))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  state_t            state, state_nxt;
  logic              take;
  logic              err_set;
  logic              fifo_full, fifo_empty;
  logic              pop;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_q;

  // ---- stage p0: byte packer ----
  logic [1:0]  lane_p0;
  logic [31:0] pack_p0;
  logic        vld_p0;
  logic [31:0] word_p0;
  logic [3:0]  be_p0;

  // ---- stage p1: word FIFO towards the Avalon master ----
  logic [31:0] fifo_data_p1 [FIFO_DEPTH];
  logic [3:0]  fifo_be_p1   [FIFO_DEPTH];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && !avl_waitrequest;

  assign word_p0 = merge_word(pack_p0, lane_p0, st_data);
  assign be_p0   = lane_mask(lane_p0);
  assign vld_p0  = take && ((lane_p0 == 2'd3) || st_eof);

  // Head of the FIFO is presented directly; an empty FIFO shows all zeros.
  assign avl_write      = !fifo_empty;
  assign avl_writedata  = fifo_empty ? 32'h0 : fifo_data_p1[rd_ptr[PTR_W-1:0]];
  assign avl_byteenable = fifo_empty ? 4'h0  : fifo_be_p1[rd_ptr[PTR_W-1:0]];
  assign avl_address    = addr_q;

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state, handshake and error detection.
  always_comb begin
    state_nxt  = state;
    st_ready   = 1'b0;
    frame_done = 1'b0;
    take       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          if (st_sof) begin
            take      = 1'b1;
            state_nxt = st_eof ? DRAIN : RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RUN: begin
        st_ready = !fifo_full;
        if (st_valid && !fifo_full) begin
          take = 1'b1;
          if (st_sof)
            err_set = 1'b1;
          if (st_eof)
            state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty)
          state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane position within the current word; restarts after every push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lane_p0 <= 2'd0;
    else if (take)
      lane_p0 <= vld_p0 ? 2'd0 : lane_p0 + 2'd1;
  end

  // Held bytes of the partial word; stale lanes are masked by merge_word.
  always_ff @(posedge clk) begin
    if (take)
      pack_p0[{lane_p0, 3'b000} +: 8] <= st_data;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      fifo_data_p1[wr_ptr[PTR_W-1:0]] <= word_p0;
      fifo_be_p1[wr_ptr[PTR_W-1:0]]   <= be_p0;
    end
  end

  // FIFO pointers; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p0)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Write address: advances per accepted write, rewinds at the end of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      addr_q <= BASE;
    else if (state == DONE)
      addr_q <= BASE;
    else if (pop)
      addr_q <= addr_q + ADDR_W'(1);
  end

  // Completed-frame counter and sticky framing error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
      err_sync  <= 1'b0;
    end else begin
      if (state == DONE)
        frame_cnt <= frame_cnt + 16'd1;
      if (err_set)
        err_sync <= 1'b1;
    end
  end

endmodule
